alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle_pkg.sv | 40 ++++
 rtl/alu_iter_muldiv.sv | 90 +++++++++
 rtl/alu_multicycle.sv | 120 ++++++++++++
 tb/tb_alu_multicycle.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_multicycle_pkg.sv
// Shared ALU op encoding, FSM states and the iterative-op classifier.
// ALU_MULTICYCLE_FAST_MUL_EN moves MUL onto the single-cycle path.
package alu_multicycle_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_XOR   = 4'd2,
    OP_OR    = 4'd3,
    OP_AND   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_PASSA = 4'd10,
    OP_PASSB = 4'd11,
    OP_ABS   = 4'd12,
    OP_MUL   = 4'd13,
    OP_DIV   = 4'd14,
    OP_REM   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(input alu_op_e op);
`ifdef ALU_MULTICYCLE_FAST_MUL_EN
    return (op == OP_DIV) || (op == OP_REM);
`else
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Radix-2 engine: shift-add multiply (low N bits) and restoring unsigned divide.
// One step per cycle for N cycles after start; done_o flags the final step.
module alu_iter_muldiv
  import alu_multicycle_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  alu_op_e      op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] result_o,
  output logic         dz_o
);

  localparam int CW = SHW + 1;

  alu_op_e        op_q, op_d;
  logic [N-1:0]   acc_q, acc_d;   // MUL partial product / DIV partial remainder
  logic [N-1:0]   x_q, x_d;       // MUL multiplicand / DIV dividend shifting into quotient
  logic [N-1:0]   y_q, y_d;       // MUL multiplier / DIV divisor
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic [N:0]     rem_shift;
  logic           q_bit;

  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    rem_shift = '0;
    q_bit     = 1'b0;
    if (start_i) begin
      op_d  = op_i;
      acc_d = '0;
      x_d   = a_i;
      y_d   = b_i;
      cnt_d = CW'(N);
      dz_d  = (op_i != OP_MUL) && (b_i == '0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (op_q == OP_MUL) begin
        acc_d = acc_q + (y_q[0] ? x_q : '0);
        x_d   = {x_q[N-2:0], 1'b0};
        y_d   = {1'b0, y_q[N-1:1]};
      end else begin
        // A zero divisor always "fits", so quotient fills with ones and the
        // remainder ends up holding the dividend -- exactly the b==0 results.
        rem_shift = {acc_q, x_q[N-1]};
        if (rem_shift >= {1'b0, y_q}) begin
          acc_d = rem_shift[N-1:0] - y_q;
          q_bit = 1'b1;
        end else begin
          acc_d = rem_shift[N-1:0];
        end
        x_d = {x_q[N-2:0], q_bit};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_ADD;
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

  assign done_o   = (cnt_q == CW'(1));
  assign result_o = (op_q == OP_DIV) ? x_d : acc_d;
  assign dz_o     = dz_q;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU, one op in flight: simple ops 1 cycle, MUL/DIV/REM N+1 cycles; result held until out_ready.
// ALU_MULTICYCLE_FAST_MUL_EN makes MUL single-cycle.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    o,
  output logic            out_dz
);

  alu_op_e      op_e;
  state_e       state_q, state_d;
  logic [N-1:0] o_q, o_d;
  logic         dz_q, dz_d;
  logic [N-1:0] alu_res;
  logic         iter_start;
  logic         iter_done;
  logic [N-1:0] iter_res;
  logic         iter_dz;

  assign op_e       = alu_op_e'(op);
  assign iter_start = (state_q == IDLE) && in_valid && is_iterative(op_e);

  always_comb begin
    alu_res = '0;
    case (op_e)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_XOR:   alu_res = a ^ b;
      OP_OR:    alu_res = a | b;
      OP_AND:   alu_res = a & b;
      OP_SLL:   alu_res = a << b[SHW-1:0];
      OP_SRL:   alu_res = a >> b[SHW-1:0];
      OP_SRA:   alu_res = $signed(a) >>> b[SHW-1:0];
      OP_SLT:   alu_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  alu_res = {{(N-1){1'b0}}, (a < b)};
      OP_PASSA: alu_res = a;
      OP_PASSB: alu_res = b;
      OP_ABS:   alu_res = a[N-1] ? (~a + N'(1)) : a;
`ifdef ALU_MULTICYCLE_FAST_MUL_EN
      OP_MUL:   alu_res = a * b;
`endif
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_iterative(op_e)) begin
            state_d = BUSY;
          end else begin
            o_d     = alu_res;
            dz_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (iter_done) begin
          o_d     = iter_res;
          dz_d    = iter_dz;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      o_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      dz_q    <= dz_d;
    end
  end

  alu_iter_muldiv #(
    .N   (N),
    .SHW (SHW)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (iter_start),
    .op_i     (op_e),
    .a_i      (a),
    .b_i      (b),
    .done_o   (iter_done),
    .result_o (iter_res),
    .dz_o     (iter_dz)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign o         = o_q;
  assign out_dz    = dz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at N=32; honours ALU_MULTICYCLE_FAST_MUL_EN for MUL latency.
module tb_alu_multicycle;

  localparam int N = 32;

  typedef struct packed {
    logic         dz;
    logic [N-1:0] o;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] o;
  logic         out_dz;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef ALU_MULTICYCLE_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = N + 1;
`endif

  always #5 clk = ~clk;

  alu_multicycle #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .out_dz    (out_dz)
  );

  function automatic res_t model(input logic [3:0] f, input logic [N-1:0] x, input logic [N-1:0] y);
    res_t r;
    r.dz = 1'b0;
    r.o  = '0;
    case (f)
      4'd0:  r.o = x + y;
      4'd1:  r.o = x - y;
      4'd2:  r.o = x ^ y;
      4'd3:  r.o = x | y;
      4'd4:  r.o = x & y;
      4'd5:  r.o = x << y[4:0];
      4'd6:  r.o = x >> y[4:0];
      4'd7:  r.o = $signed(x) >>> y[4:0];
      4'd8:  r.o = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:  r.o = (x < y) ? 32'd1 : 32'd0;
      4'd10: r.o = x;
      4'd11: r.o = y;
      4'd12: r.o = x[N-1] ? 32'd0 - x : x;
      4'd13: r.o = x * y;
      4'd14: begin r.dz = (y == 0); r.o = (y == 0) ? 32'hFFFF_FFFF : x / y; end
      default: begin r.dz = (y == 0); r.o = (y == 0) ? x : x % y; end
    endcase
    return r;
  endfunction

  // Drives one op, pushes its expected result, waits for out_valid, holds
  // out_ready low for 'hold' cycles, then pops and compares on transfer.
  task automatic send_op(input logic [3:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                         input int hold, output int lat);
    res_t exp_r;
    int   busy_bad;
    logic [N-1:0] first_o;
    @(negedge clk);
    out_ready = (hold == 0);
    op = f; a = x; b = y; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL send_in_ready op=%0d got=%b want=1", f, in_ready); end
    sb.push_back(model(f, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    busy_bad = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL busy_in_ready op=%0d got=%0d_high_cycles want=0", f, busy_bad); end
    exp_r = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL out_valid_timeout op=%0d got=%b want=1", f, out_valid);
      out_ready = 1'b1;
      return;
    end
    first_o = o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin a = ~a; b = ~b; in_valid = 1'b1; end
      checks++;
      if (out_valid !== 1'b1 || o !== first_o) begin
        errors++; $display("FAIL stall_hold op=%0d cyc=%0d got=%b/%h want=1/%h", f, i, out_valid, o, first_o);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (o !== exp_r.o) begin errors++; $display("FAIL result op=%0d got=%h want=%h", f, o, exp_r.o); end
    checks++;
    if (out_dz !== exp_r.dz) begin errors++; $display("FAIL out_dz op=%0d got=%b want=%b", f, out_dz, exp_r.dz); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL drain op=%0d got=%b/%b want=0/1", f, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs got=%b/%b want=1/0", in_ready, out_valid);
    end
    checks++;
    if (o !== '0 || out_dz !== 1'b0) begin errors++; $display("FAIL reset_out got=%h/%b want=0/0", o, out_dz); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got=%b want=0", out_valid); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]   t_op[14] = '{4'd0, 4'd7, 4'd8, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11, 4'd12, 4'd12};
    logic [N-1:0] t_a[14]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hF0F0_1234,
                               32'h0F00_0001, 32'hFF00_FF00, 32'h1, 32'h8000_0000, 32'hCAFE_BABE, 32'h1, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [N-1:0] t_b[14]  = '{32'h1, 32'h21, 32'h0, 32'h0, 32'h1, 32'h0FF0_FFFF,
                               32'h00F0_0010, 32'h0FF0_0FF0, 32'h3F, 32'h24, 32'h5, 32'hDEAD_BEEF, 32'h0, 32'h0};
    int lat;
    for (int i = 0; i < 14; i++) begin
      send_op(t_op[i], t_a[i], t_b[i], 0, lat);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL simple_latency op=%0d got=%0d want=1", t_op[i], lat); end
    end
  endtask

  task automatic test_div();
    int lat;
    send_op(4'd14, 32'd100, 32'd7, 0, lat);
    checks++;
    if (lat != N + 1) begin errors++; $display("FAIL div_latency got=%0d want=%0d", lat, N + 1); end
    send_op(4'd15, 32'd100, 32'd7, 0, lat);
    checks++;
    if (lat != N + 1) begin errors++; $display("FAIL rem_latency got=%0d want=%0d", lat, N + 1); end
    send_op(4'd14, 32'hFFFF_FFFF, 32'h0001_0001, 0, lat);
  endtask

  task automatic test_div_zero();
    int lat;
    send_op(4'd14, 32'd5, 32'd0, 0, lat);
    checks++;
    if (lat != N + 1) begin errors++; $display("FAIL divz_latency got=%0d want=%0d", lat, N + 1); end
    send_op(4'd15, 32'd5, 32'd0, 0, lat);
    checks++;
    if (lat != N + 1) begin errors++; $display("FAIL remz_latency got=%0d want=%0d", lat, N + 1); end
  endtask

  task automatic test_mul_stall();
    int lat;
    send_op(4'd13, 32'h0001_0000, 32'h0001_0003, 5, lat);
    checks++;
    if (lat != MUL_LAT) begin errors++; $display("FAIL mul_latency got=%0d want=%0d", lat, MUL_LAT); end
    send_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    send_op(4'd13, 32'd12345, 32'd6789, 0, lat);
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    @(negedge clk);
    op = 4'd14; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_state got=%b/%b want=1/0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < N + 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_result got=%0d want=0", seen); end
    send_op(4'd0, 32'd2, 32'd3, 0, lat);
  endtask

  task automatic test_back_to_back();
    res_t exp_r;
    @(negedge clk);
    out_ready = 1'b0;
    op = 4'd0; a = 32'd7; b = 32'd8; in_valid = 1'b1;
    sb.push_back(model(4'd0, 32'd7, 32'd8));
    @(posedge clk); #1;
    op = 4'd1; a = 32'd1; b = 32'd3;
    exp_r = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || o !== exp_r.o) begin
      errors++; $display("FAIL b2b_first got=%b/%h want=1/%h", out_valid, o, exp_r.o);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_no_bypass got=%b/%b want=0/1", out_valid, in_ready);
    end
    sb.push_back(model(4'd1, 32'd1, 32'd3));
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_r = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || o !== exp_r.o) begin
      errors++; $display("FAIL b2b_second got=%b/%h want=1/%h", out_valid, o, exp_r.o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_div();
    test_div_zero();
    test_mul_stall();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty got=%0d want=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
